// File: rtl/mesh_pkg.sv
// Shared mesh write-request definitions: default credit grant and payload layout.
package mesh_pkg;

    localparam int MESH_WR_REQ_CRDTS = 4;
    localparam int MESH_ADDR_W       = 20;
    localparam int MESH_DATA_W       = 64;

    typedef struct packed {
        logic [MESH_ADDR_W-1:0] addr;
        logic [MESH_DATA_W-1:0] data;
    } mesh_wr_req_t;

endpackage

// File: rtl/msh_tx_fifo.sv
// Synchronous client-side FIFO with registered full flag and occupancy count.
module msh_tx_fifo #(
    parameter int WIDTH = 84,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             rdy,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_next;
    logic             full_q;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign wr_en    = push & ~full_q;
    assign rd_en    = pop & ~empty;
    assign rdy      = ~full_q;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        cnt_next = cnt_q;
        if (wr_en & ~rd_en) begin
            cnt_next = cnt_q + 1'b1;
        end else if (rd_en & ~wr_en) begin
            cnt_next = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            cnt_q  <= cnt_next;
            full_q <= (cnt_next == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/msh_wr_req_tx.sv
// Credit-based mesh write-request transmitter: client FIFO, credit counter,
// single-cycle launch stage and sticky credit-overflow flag.
module msh_wr_req_tx
    import mesh_pkg::*;
#(
    parameter int NUM_CRDTS  = MESH_WR_REQ_CRDTS,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 64
) (
    input  logic              mclk,
    input  logic              i_reset_n,
    input  logic              i_req_vld,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_req_rdy,
    output logic              o_wr_req_vld,
    output logic [ADDR_W-1:0] o_wr_req_addr,
    output logic [DATA_W-1:0] o_wr_dbus,
    input  logic              i_crdt_rtn,
    output logic [3:0]        o_crdt_cnt,
    output logic              o_idle,
    output logic              o_crdt_err
);
    localparam int         W         = ADDR_W + DATA_W;
    localparam logic [3:0] CRDT_FULL = 4'(NUM_CRDTS);

    logic [W-1:0] head;
    logic         fifo_empty;
    logic         launch;
    logic [3:0]   crdt_cnt;

    msh_tx_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (mclk),
        .rst_n     (i_reset_n),
        .push      (i_req_vld),
        .push_data ({i_req_addr, i_req_data}),
        .pop       (launch),
        .pop_data  (head),
        .rdy       (o_req_rdy),
        .empty     (fifo_empty)
    );

    // Uses the registered count, so a same-cycle return only helps next cycle.
    assign launch     = ~fifo_empty & (crdt_cnt != 4'd0);
    assign o_crdt_cnt = crdt_cnt;
    assign o_idle     = fifo_empty & ~o_wr_req_vld & (crdt_cnt == CRDT_FULL);

    always_ff @(posedge mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crdt_cnt   <= CRDT_FULL;
            o_crdt_err <= 1'b0;
        end else begin
            unique case ({launch, i_crdt_rtn})
                2'b10: crdt_cnt <= crdt_cnt - 4'd1;
                2'b01: begin
                    if (crdt_cnt == CRDT_FULL) o_crdt_err <= 1'b1;
                    else                       crdt_cnt   <= crdt_cnt + 4'd1;
                end
                default: crdt_cnt <= crdt_cnt;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_req_vld  <= 1'b0;
            o_wr_req_addr <= '0;
            o_wr_dbus     <= '0;
        end else begin
            o_wr_req_vld <= launch;
            if (launch) begin
                o_wr_req_addr <= head[W-1 -: ADDR_W];
                o_wr_dbus     <= head[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_msh_wr_req_tx.sv
// Self-checking bench for msh_wr_req_tx against a queue-based transaction model.
module tb_msh_wr_req_tx;
    import mesh_pkg::*;

    localparam int NC = 4;
    localparam int FD = 4;
    localparam int AW = 20;
    localparam int DW = 64;

    logic          mclk = 1'b0;
    logic          i_reset_n;
    logic          i_req_vld;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_data;
    logic          o_req_rdy;
    logic          o_wr_req_vld;
    logic [AW-1:0] o_wr_req_addr;
    logic [DW-1:0] o_wr_dbus;
    logic          i_crdt_rtn;
    logic [3:0]    o_crdt_cnt;
    logic          o_idle;
    logic          o_crdt_err;

    msh_wr_req_tx #(
        .NUM_CRDTS  (NC),
        .FIFO_DEPTH (FD),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .mclk          (mclk),
        .i_reset_n     (i_reset_n),
        .i_req_vld     (i_req_vld),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_req_rdy     (o_req_rdy),
        .o_wr_req_vld  (o_wr_req_vld),
        .o_wr_req_addr (o_wr_req_addr),
        .o_wr_dbus     (o_wr_dbus),
        .i_crdt_rtn    (i_crdt_rtn),
        .o_crdt_cnt    (o_crdt_cnt),
        .o_idle        (o_idle),
        .o_crdt_err    (o_crdt_err)
    );

    always #5 mclk = ~mclk;

    int errors = 0;
    int checks = 0;
    int seen_launches = 0;

    // Reference model: pending requests, credits held, last launched request.
    mesh_wr_req_t  m_q[$];
    int            m_cred;
    bit            m_err;
    bit            m_vld;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_cred = NC;
        m_err  = 1'b0;
        m_vld  = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic compare();
        chk("vld",  64'(o_wr_req_vld), 64'(m_vld));
        chk("addr", 64'(o_wr_req_addr), 64'(m_addr));
        chk("data", o_wr_dbus, m_data);
        chk("cnt",  64'(o_crdt_cnt), 64'(m_cred));
        chk("rdy",  64'(o_req_rdy), 64'(m_q.size() < FD));
        chk("idle", 64'(o_idle), 64'(m_q.size() == 0 && !m_vld && m_cred == NC));
        chk("err",  64'(o_crdt_err), 64'(m_err));
    endtask

    // Called at a falling edge: drive inputs, advance the model across the
    // coming rising edge, then compare at the next falling edge.
    task automatic cycle(input bit vld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit rtn);
        bit push;
        bit launch;
        mesh_wr_req_t r;
        i_req_vld  = vld;
        i_req_addr = a;
        i_req_data = d;
        i_crdt_rtn = rtn;
        push   = vld && (m_q.size() < FD);
        launch = (m_q.size() > 0) && (m_cred > 0);
        m_vld  = launch;
        if (launch) begin
            r      = m_q.pop_front();
            m_addr = r.addr;
            m_data = r.data;
        end
        if (push) m_q.push_back('{addr: a, data: d});
        if (launch && !rtn) m_cred--;
        else if (!launch && rtn) begin
            if (m_cred == NC) m_err = 1'b1;
            else              m_cred++;
        end
        @(negedge mclk);
        if (o_wr_req_vld) seen_launches++;
        compare();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic ret(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        i_reset_n  = 1'b0;
        i_req_vld  = 1'b0;
        i_req_addr = '0;
        i_req_data = '0;
        i_crdt_rtn = 1'b0;
        m_reset();
        repeat (2) @(negedge mclk);
        compare();
        i_reset_n = 1'b1;
        idle(2);

        // Single request: push then launch two cycles later.
        cycle(1'b1, 20'h00012, 64'hDEAD_BEEF, 1'b0);
        cycle(1'b0, '0, '0, 1'b0);
        chk("single_vld",  64'(o_wr_req_vld), 64'd1);
        chk("single_addr", 64'(o_wr_req_addr), 64'h12);
        chk("single_cnt",  64'(o_crdt_cnt), 64'd3);
        idle(2);
        ret(1);
        idle(1);

        // Overflow in idle state: saturates and sets the sticky error.
        ret(1);
        chk("ovf_cnt", 64'(o_crdt_cnt), 64'd4);
        chk("ovf_err", 64'(o_crdt_err), 64'd1);
        idle(3);
        chk("ovf_sticky", 64'(o_crdt_err), 64'd1);

        // Credit exhaustion: six pushes, only four launch.
        seen_launches = 0;
        for (int k = 0; k < 6; k++) cycle(1'b1, AW'(k + 16'h100), DW'(k), 1'b0);
        idle(4);
        chk("exhaust_launches", 64'(seen_launches), 64'd4);
        chk("exhaust_cnt",      64'(o_crdt_cnt), 64'd0);
        chk("exhaust_vld",      64'(o_wr_req_vld), 64'd0);

        // Refill: each return releases one pending request.
        ret(1);
        cycle(1'b0, '0, '0, 1'b0);
        chk("refill_5th", o_wr_dbus, 64'd4);
        ret(1);
        cycle(1'b0, '0, '0, 1'b0);
        chk("refill_6th", o_wr_dbus, 64'd5);
        ret(3);
        chk("refill_not_idle", 64'(o_idle), 64'd0);
        ret(1);
        chk("refill_idle", 64'(o_idle), 64'd1);

        // Simultaneous launch and return holds the count.
        cycle(1'b1, 20'h00A01, 64'h1, 1'b0);
        cycle(1'b1, 20'h00A02, 64'h2, 1'b0);
        idle(2);
        chk("sim_pre_cnt", 64'(o_crdt_cnt), 64'd2);
        cycle(1'b1, 20'h00A03, 64'h3, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        chk("sim_cnt", 64'(o_crdt_cnt), 64'd2);
        ret(2);
        idle(1);

        // Full FIFO with no credits, then asynchronous reset.
        for (int k = 0; k < 4; k++) cycle(1'b1, AW'(k + 16'h200), DW'(k), 1'b0);
        idle(2);
        for (int k = 0; k < 6; k++) cycle(1'b1, AW'(k + 16'h300), DW'(k + 64'h30), 1'b0);
        chk("full_rdy", 64'(o_req_rdy), 64'd0);
        @(posedge mclk);
        #2 i_reset_n = 1'b0;
        m_reset();
        #1 compare();
        chk("rst_cnt", 64'(o_crdt_cnt), 64'd4);
        @(negedge mclk);
        i_req_vld = 1'b0;
        i_reset_n = 1'b1;
        compare();
        seen_launches = 0;
        idle(5);
        chk("rst_no_launch", 64'(seen_launches), 64'd0);
        cycle(1'b1, 20'h00777, 64'h77, 1'b0);
        idle(2);

        // Randomized traffic with only legal credit returns.
        for (int k = 0; k < 400; k++) begin
            bit rv;
            bit rr;
            rv = ($urandom_range(0, 99) < 60);
            rr = (m_cred < NC) && ($urandom_range(0, 99) < 45);
            cycle(rv, AW'($urandom), {$urandom, $urandom}, rr);
        end
        while (m_cred < NC || m_q.size() > 0 || m_vld) begin
            if (checks > 20000) break;
            cycle(1'b0, '0, '0, (m_cred < NC));
        end
        chk("final_idle", 64'(o_idle), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
